// File: rtl/serdes_noise_channel.sv
// serdes_noise_channel
//   Repeatable error-injection channel placed between the PHY SERDES TX and
//   RX sides. A 32-bit Galois LFSR decides, per block, whether to corrupt the
//   sync header or flip one data bit, optionally stretching each hit into a
//   burst. Counters report blocks passed, blocks corrupted and the current
//   run of clean blocks so lock / high-BER thresholds can be characterised.
//
// Ports
//   clk_tb, rx_rst_tb      block clock, async active-high reset
//   in_data, in_hdr        TX block from the PHY
//   cfg_enable             run request (level)
//   cfg_clear              sync pulse: zero counters, reload LFSR, go idle
//   cfg_mode               00 hdr=11, 01 hdr=00, 10 hdr inverted, 11 data bit flip
//   cfg_thresh             trigger when lfsr[15:0] < thresh (FFFF = always)
//   cfg_burst_len          blocks per trigger (0 and 1 both mean 1)
//   cfg_block_limit        blocks to run, 0 = unlimited
//   out_data, out_hdr      block to the PHY RX, one cycle after input
//   out_err                current output block was corrupted
//   blk_count, inj_count   saturating block / corrupted-block counters
//   clean_run              saturating consecutive-clean-block counter
//   done                   block limit reached
module serdes_noise_channel #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH  = 2,
  parameter logic [31:0] SEED       = 32'hACE12468
) (
  input  logic                  clk_tb,
  input  logic                  rx_rst_tb,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  cfg_enable,
  input  logic                  cfg_clear,
  input  logic [1:0]            cfg_mode,
  input  logic [15:0]           cfg_thresh,
  input  logic [3:0]            cfg_burst_len,
  input  logic [31:0]           cfg_block_limit,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_err,
  output logic [31:0]           blk_count,
  output logic [31:0]           inj_count,
  output logic [15:0]           clean_run,
  output logic                  done
);

  localparam int unsigned POS_W = $clog2(DATA_WIDTH);
  localparam logic [31:0] TAPS  = 32'h80200003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BURST,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [3:0]              burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;
  logic                    out_err_q, out_err_d;
  logic [31:0]             blk_count_q, blk_count_d;
  logic [31:0]             inj_count_q, inj_count_d;
  logic [15:0]             clean_run_q, clean_run_d;
  logic                    done_q, done_d;

  logic                    active;
  logic                    trigger;
  logic                    corrupt;
  logic [POS_W-1:0]        flip_pos;
  logic [DATA_WIDTH-1:0]   flip_mask;
  logic [31:0]             blk_next;
  logic [31:0]             lfsr_step;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    burst_cnt_d = burst_cnt_q;
    blk_count_d = blk_count_q;
    inj_count_d = inj_count_q;
    clean_run_d = clean_run_q;
    done_d      = (state_q == S_DONE);
    out_data_d  = in_data;
    out_hdr_d   = in_hdr;
    out_err_d   = 1'b0;

    active    = (state_q == S_RUN) || (state_q == S_BURST);
    trigger   = (cfg_thresh == 16'hFFFF) || (lfsr_q[15:0] < cfg_thresh);
    corrupt   = (state_q == S_BURST) || ((state_q == S_RUN) && trigger);
    flip_pos  = lfsr_q[16 +: POS_W];
    flip_mask = '0;
    flip_mask[flip_pos] = 1'b1;
    blk_next  = (blk_count_q == '1) ? blk_count_q : blk_count_q + 32'd1;
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : '0);

    if (cfg_clear) begin
      state_d     = S_IDLE;
      lfsr_d      = SEED;
      burst_cnt_d = '0;
      blk_count_d = '0;
      inj_count_d = '0;
      clean_run_d = '0;
      done_d      = 1'b0;
    end else if (active) begin
      lfsr_d      = lfsr_step;
      blk_count_d = blk_next;

      if (corrupt) begin
        out_err_d   = 1'b1;
        inj_count_d = (inj_count_q == '1) ? inj_count_q : inj_count_q + 32'd1;
        clean_run_d = '0;
        unique case (cfg_mode)
          2'b00:   out_hdr_d  = '1;
          2'b01:   out_hdr_d  = '0;
          2'b10:   out_hdr_d  = ~in_hdr;
          default: out_data_d = in_data ^ flip_mask;
        endcase
      end else begin
        clean_run_d = (clean_run_q == '1) ? clean_run_q : clean_run_q + 16'd1;
      end

      if (state_q == S_RUN) begin
        if (trigger && (cfg_burst_len > 4'd1)) begin
          burst_cnt_d = cfg_burst_len - 4'd1;
          state_d     = S_BURST;
        end
      end else begin
        burst_cnt_d = (burst_cnt_q == '0) ? burst_cnt_q : burst_cnt_q - 4'd1;
        state_d     = (burst_cnt_q <= 4'd1) ? S_RUN : S_BURST;
      end

      // Limit wins over burst continuation; enable drop keeps burst_cnt so
      // a half-finished burst resumes from IDLE.
      if ((cfg_block_limit != '0) && (blk_next == cfg_block_limit)) begin
        state_d = S_DONE;
      end else if (!cfg_enable) begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_IDLE) begin
      if (cfg_enable && !done_q) begin
        state_d = (burst_cnt_q != '0) ? S_BURST : S_RUN;
      end
    end
  end

  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_hdr_q   <= '0;
      out_err_q   <= 1'b0;
      blk_count_q <= '0;
      inj_count_q <= '0;
      clean_run_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_hdr_q   <= out_hdr_d;
      out_err_q   <= out_err_d;
      blk_count_q <= blk_count_d;
      inj_count_q <= inj_count_d;
      clean_run_q <= clean_run_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_hdr   = out_hdr_q;
  assign out_err   = out_err_q;
  assign blk_count = blk_count_q;
  assign inj_count = inj_count_q;
  assign clean_run = clean_run_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serdes_noise_channel.sv
// tb_serdes_noise_channel
//   Bench for serdes_noise_channel: a block-level reference model (running /
//   finished flags, remaining forced blocks, plain counters) predicts every
//   output each cycle; directed phases exercise pass-through, forced header
//   errors, data-bit flips, bursts, enable drop, mid-burst reset and
//   clear-with-enable.
module tb_serdes_noise_channel;

  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk_tb = 1'b0;
  logic        rx_rst_tb;
  logic [63:0] in_data;
  logic [1:0]  in_hdr;
  logic        cfg_enable;
  logic        cfg_clear;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_thresh;
  logic [3:0]  cfg_burst_len;
  logic [31:0] cfg_block_limit;
  logic [63:0] out_data;
  logic [1:0]  out_hdr;
  logic        out_err;
  logic [31:0] blk_count;
  logic [31:0] inj_count;
  logic [15:0] clean_run;
  logic        done;

  serdes_noise_channel #(
    .DATA_WIDTH(64),
    .HDR_WIDTH (2),
    .SEED      (SEED)
  ) dut (
    .clk_tb         (clk_tb),
    .rx_rst_tb      (rx_rst_tb),
    .in_data        (in_data),
    .in_hdr         (in_hdr),
    .cfg_enable     (cfg_enable),
    .cfg_clear      (cfg_clear),
    .cfg_mode       (cfg_mode),
    .cfg_thresh     (cfg_thresh),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_block_limit(cfg_block_limit),
    .out_data       (out_data),
    .out_hdr        (out_hdr),
    .out_err        (out_err),
    .blk_count      (blk_count),
    .inj_count      (inj_count),
    .clean_run      (clean_run),
    .done           (done)
  );

  always #5 clk_tb = ~clk_tb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [63:0] sat(input longint unsigned v, input longint unsigned mx);
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0]     m_lfsr  = SEED;
  bit              m_run   = 0;
  bit              m_fin   = 0;
  int              m_left  = 0;
  longint unsigned m_blk   = 0;
  longint unsigned m_inj   = 0;
  longint unsigned m_clean = 0;
  logic [63:0]     e_data  = '0;
  logic [1:0]      e_hdr   = '0;
  logic            e_err   = 1'b0;
  logic            e_done  = 1'b0;

  task automatic model_step(input logic rst, input logic clr, input logic en,
                            input logic [1:0] mode, input logic [15:0] thresh,
                            input logic [3:0] blen, input logic [31:0] limit,
                            input logic [63:0] din, input logic [1:0] hin);
    bit trig;
    bit bad;
    int len;
    if (rst) begin
      m_lfsr = SEED; m_run = 0; m_fin = 0; m_left = 0;
      m_blk = 0; m_inj = 0; m_clean = 0;
      e_data = '0; e_hdr = '0; e_err = 1'b0; e_done = 1'b0;
      return;
    end
    e_data = din;
    e_hdr  = hin;
    e_err  = 1'b0;
    if (clr) begin
      m_lfsr = SEED; m_run = 0; m_fin = 0; m_left = 0;
      m_blk = 0; m_inj = 0; m_clean = 0;
      e_done = 1'b0;
      return;
    end
    e_done = m_fin;
    if (m_run) begin
      trig = (thresh == 16'hFFFF) || (m_lfsr[15:0] < thresh);
      bad  = (m_left > 0) || trig;
      len  = (blen == 0) ? 1 : int'(blen);
      if (m_left > 0) m_left--;
      else if (trig && len > 1) m_left = len - 1;
      m_blk++;
      if (bad) begin
        e_err = 1'b1;
        m_inj++;
        m_clean = 0;
        case (mode)
          2'd0: e_hdr = 2'b11;
          2'd1: e_hdr = 2'b00;
          2'd2: e_hdr = ~hin;
          default: e_data = din ^ (64'd1 << m_lfsr[21:16]);
        endcase
      end else begin
        m_clean++;
      end
      m_lfsr = lfsr_next(m_lfsr);
      if (limit != 0 && sat(m_blk, 64'hFFFFFFFF) == 64'(limit)) begin
        m_run = 0;
        m_fin = 1;
      end else if (!en) begin
        m_run = 0;
      end
    end else if (en && !m_fin) begin
      m_run = 1;
    end
  endtask

  // ---------------- compare process ----------------
  bit          data_phase  = 0;
  bit          burst_phase = 0;
  int          pin_idx     = 0;
  int          run_len     = 0;
  logic [63:0] s_data;
  logic [63:0] pin_exp [4];

  initial begin
    pin_exp[0] = 64'd1 << 33;
    pin_exp[1] = 64'd1 << 48;
    pin_exp[2] = 64'd1 << 56;
    pin_exp[3] = 64'd1 << 28;
  end

  always @(posedge clk_tb) begin
    logic [63:0] x;
    s_data = in_data;
    model_step(rx_rst_tb, cfg_clear, cfg_enable, cfg_mode, cfg_thresh,
               cfg_burst_len, cfg_block_limit, in_data, in_hdr);
    #1;
    chk("out_data",  out_data,  e_data);
    chk("out_hdr",   64'(out_hdr), 64'(e_hdr));
    chk("out_err",   64'(out_err), 64'(e_err));
    chk("blk_count", 64'(blk_count), sat(m_blk, 64'hFFFFFFFF));
    chk("inj_count", 64'(inj_count), sat(m_inj, 64'hFFFFFFFF));
    chk("clean_run", 64'(clean_run), sat(m_clean, 64'hFFFF));
    chk("done",      64'(done), 64'(e_done));
    if (data_phase && out_err) begin
      x = out_data ^ s_data;
      chk("flip_popcount", 64'($countones(x)), 64'd1);
      if (pin_idx < 4) begin
        chk("flip_pin", x, pin_exp[pin_idx]);
        pin_idx++;
      end
    end
    if (burst_phase) begin
      if (out_err) begin
        run_len++;
      end else begin
        if (run_len > 0 && !done) begin
          n_cmp++;
          if (run_len < 4) begin
            n_bad++;
            $display("FAIL burst_len: got %0d expected >=4 at %0t", run_len, $time);
          end
        end
        run_len = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_tb);
      in_data = {$urandom(), $urandom()};
      in_hdr  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    tick(1);
    cfg_clear = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] th, input logic [1:0] md,
                         input logic [3:0] bl, input logic [31:0] lim);
    cfg_thresh = th; cfg_mode = md; cfg_burst_len = bl; cfg_block_limit = lim;
  endtask

  initial begin
    logic [31:0] s;
    rx_rst_tb = 1'b1;
    in_data = '0; in_hdr = '0;
    cfg_enable = 1'b0; cfg_clear = 1'b0;
    set_cfg(16'd0, 2'd0, 4'd0, 32'd0);
    tick(2);

    // reset state
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_hdr", 64'(out_hdr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_blk", 64'(blk_count), 64'd0);
    chk("rst_inj", 64'(inj_count), 64'd0);
    chk("rst_clean", 64'(clean_run), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // model LFSR pins
    s = lfsr_next(SEED);
    chk("lfsr_pin1", 64'(s), 64'h56709234);
    s = lfsr_next(lfsr_next(lfsr_next(s)));
    chk("lfsr_pin4", 64'(s), 64'h8AEE1245);

    rx_rst_tb = 1'b0;

    // clean pass-through
    set_cfg(16'd0, 2'd0, 4'd0, 32'd500);
    cfg_enable = 1'b1;
    tick(503);
    chk("clean_blk", 64'(blk_count), 64'd500);
    chk("clean_inj", 64'(inj_count), 64'd0);
    chk("clean_run500", 64'(clean_run), 64'd500);
    chk("clean_done", 64'(done), 64'd1);

    // forced header errors
    cfg_enable = 1'b0;
    do_clear();
    set_cfg(16'hFFFF, 2'd0, 4'd0, 32'd10);
    cfg_enable = 1'b1;
    tick(13);
    chk("hdr_inj", 64'(inj_count), 64'd10);
    chk("hdr_blk", 64'(blk_count), 64'd10);
    chk("hdr_done", 64'(done), 64'd1);

    // data-bit mode
    cfg_enable = 1'b0;
    do_clear();
    set_cfg(16'hFFFF, 2'd3, 4'd1, 32'd64);
    data_phase = 1;
    cfg_enable = 1'b1;
    tick(67);
    data_phase = 0;
    chk("data_inj", 64'(inj_count), 64'd64);
    chk("data_pins_seen", 64'(pin_idx), 64'd4);

    // bursts against the model
    cfg_enable = 1'b0;
    do_clear();
    set_cfg(16'd655, 2'd2, 4'd4, 32'd5000);
    burst_phase = 1;
    run_len = 0;
    cfg_enable = 1'b1;
    tick(5003);
    burst_phase = 0;
    chk("burst_blk", 64'(blk_count), 64'd5000);
    chk("burst_done", 64'(done), 64'd1);

    // enable drop mid-burst, resume
    cfg_enable = 1'b0;
    do_clear();
    set_cfg(16'hFFFF, 2'd2, 4'd8, 32'd0);
    cfg_enable = 1'b1;
    tick(4);
    cfg_enable = 1'b0;
    tick(3);
    cfg_thresh = 16'd0;
    cfg_enable = 1'b1;
    tick(10);
    chk("drop_blk", 64'(blk_count), 64'd13);
    chk("drop_inj", 64'(inj_count), 64'd8);
    chk("drop_clean", 64'(clean_run), 64'd5);

    // mid-burst reset
    cfg_enable = 1'b0;
    do_clear();
    set_cfg(16'hFFFF, 2'd0, 4'd15, 32'd0);
    cfg_enable = 1'b1;
    tick(5);
    #2;
    rx_rst_tb = 1'b1;
    #1;
    chk("mrst_out_data", out_data, 64'd0);
    chk("mrst_out_hdr", 64'(out_hdr), 64'd0);
    chk("mrst_out_err", 64'(out_err), 64'd0);
    chk("mrst_blk", 64'(blk_count), 64'd0);
    cfg_enable = 1'b0;
    tick(2);
    rx_rst_tb = 1'b0;
    set_cfg(16'd655, 2'd0, 4'd4, 32'd300);
    cfg_enable = 1'b1;
    tick(305);
    chk("mrst_blk300", 64'(blk_count), 64'd300);
    chk("mrst_done", 64'(done), 64'd1);

    // clear and enable in the same cycle
    set_cfg(16'd0, 2'd0, 4'd0, 32'd0);
    cfg_clear = 1'b1;
    cfg_enable = 1'b1;
    tick(1);
    chk("ce_blk_a", 64'(blk_count), 64'd0);
    chk("ce_inj_a", 64'(inj_count), 64'd0);
    chk("ce_done_a", 64'(done), 64'd0);
    cfg_clear = 1'b0;
    tick(1);
    chk("ce_blk_b", 64'(blk_count), 64'd0);
    tick(1);
    chk("ce_blk_c", 64'(blk_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
